gate_bist_ctrl: RTL and testbench
=================================

Name: gate_bist_ctrl

Overview:
- Parametrised built-in self-test controller for the generated gate-level models in the gate library (GateModel netlists, N inputs / M outputs).
- Drives the model-under-test inputs from an LFSR pattern generator and compresses its outputs into a MISR signature.
- After a programmable pattern count, compares the signature with a golden value and reports pass/fail.
- Handles both purely combinational models and pipelined (registered) successors via a latency parameter.

Parameters:
- IN_W, 21, width of the DUT input vector; must be <= LFSR_W.
- OUT_W, 10, width of the DUT output vector; must be <= MISR_W.
- LFSR_W, 24, LFSR length.
- LFSR_TAPS, 24'hE10000, Fibonacci feedback mask (x^24+x^23+x^22+x^17+1).
- LFSR_SEED, 24'h000001, LFSR load value; must be non-zero.
- MISR_W, 16, signature width.
- MISR_POLY, 16'hB400, MISR feedback polynomial mask.
- NUM_PAT, 256, number of patterns applied; 1..2^16-1.
- DUT_LAT, 0, DUT pipeline latency in cycles; 0..15.
- GOLDEN_SIG, 16'h0000, expected final signature.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle run request; sampled only in IDLE.
- abort  in  1  cancels an active run.
- dut_in  out  IN_W  pattern to the DUT; equals lfsr[IN_W-1:0].
- dut_in_valid  out  1  high while a pattern is being applied (RUN).
- dut_out  in  OUT_W  DUT response.
- busy  out  1  high in SEED, RUN and DRAIN.
- done  out  1  high in DONE; held until the next start or abort.
- pass  out  1  valid when done=1: signature == GOLDEN_SIG.
- signature  out  MISR_W  current MISR contents.

Behaviour:
- Reset: state=IDLE; lfsr=0, misr=0, pattern counter=0, capture pipe=0. All outputs read 0: dut_in=0, dut_in_valid=0, busy=0, done=0, pass=0, signature=0. Reset mid-run discards the run with no done pulse.
- FSM states: IDLE, SEED, RUN, DRAIN, DONE.
- IDLE -> SEED on start.
- DONE -> SEED on start. This clears done and pass.
- SEED (1 cycle): lfsr<=LFSR_SEED, misr<=0, cnt<=0. Then -> RUN.
- RUN:
  - dut_in_valid=1.
  - Each cycle: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}; cnt<=cnt+1.
  - -> DRAIN when cnt==NUM_PAT-1. If DUT_LAT==0, go directly to DONE instead.
- Capture pipe:
  - valid shift register of depth DUT_LAT fed by dut_in_valid.
  - With DUT_LAT=0, capture = dut_in_valid (same-cycle sampling of a combinational DUT).
- MISR update on each capture cycle: misr <= {misr[MISR_W-2:0],1'b0} ^ (misr[MISR_W-1] ? MISR_POLY : 0) ^ zero-extended dut_out.
- DRAIN: lasts exactly DUT_LAT cycles so the last pattern's response is captured. Then -> DONE.
- DONE: done=1; pass=(misr==GOLDEN_SIG), registered on DONE entry; lfsr and misr frozen.
- abort:
  - In SEED/RUN/DRAIN: -> IDLE next cycle. busy=0, done=0; capture pipe cleared; signature retains its partial value.
  - In IDLE/DONE: ignored.
- Simultaneous start+abort in DONE: abort wins (ignored, no restart).
- start while busy: ignored.
- Latency (DUT_LAT=L): start sampled at cycle t -> SEED at t+1 -> RUN at t+2..t+1+NUM_PAT -> done=1 from cycle t+2+NUM_PAT+L.
- Counter width: 16 bits.

Test Plan:
- Reset: assert rst mid-RUN (NUM_PAT=256) -> next cycle all outputs 0, state IDLE; a following start yields a normal run.
- NUM_PAT=1, DUT_LAT=0, dut_out tied 0, GOLDEN_SIG=0:
  - start at cycle 0 -> dut_in=21'h000001 with dut_in_valid=1 at cycle 2.
  - done=1 at cycle 3; signature=16'h0000; pass=1.
- NUM_PAT=2, DUT_LAT=0, dut_out=10'h001 constant:
  - dut_in sequence is 21'h000001 then 21'h000002.
  - signature=16'h0003; with GOLDEN_SIG=0, pass=0.
- DUT_LAT=3, NUM_PAT=4, 3-stage registered identity DUT (dut_out = dut_in[9:0] delayed 3):
  - done exactly at cycle 9 after start.
  - signature equals the reference model folding 1,2,4,8 in order.
- abort asserted in the 2nd RUN cycle -> IDLE next cycle, busy=0, done=0. start pulses during RUN are ignored (no SEED re-entry).
- Default parameters, random combinational DUT model: done at cycle 258; signature matches the bench reference model; restart from DONE reproduces the identical signature.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// Built-in self-test controller for gate-level models: LFSR stimulus generation, MISR response
// compaction and a golden-signature compare after a fixed number of patterns.
module gate_bist_ctrl #(
  parameter int unsigned       IN_W       = 21,
  parameter int unsigned       OUT_W      = 10,
  parameter int unsigned       LFSR_W     = 24,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 24'hE10000,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 24'h000001,
  parameter int unsigned       MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = 16'hB400,
  parameter int unsigned       NUM_PAT    = 256,
  parameter int unsigned       DUT_LAT    = 0,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [IN_W-1:0]   dut_in,
  output logic              dut_in_valid,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  localparam logic [15:0] LastPat   = 16'(NUM_PAT - 1);
  localparam logic [15:0] LastDrain = 16'((DUT_LAT > 0) ? (DUT_LAT - 1) : 0);

  typedef enum logic [2:0] {StIdle, StSeed, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [MISR_W-1:0]   misr_q, misr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                pass_q, pass_d;
  logic                capture;
  logic                abort_hit;
  logic [MISR_W-1:0]   resp_ext;
  logic [MISR_W-1:0]   misr_next;

  assign dut_in       = lfsr_q[IN_W-1:0];
  assign dut_in_valid = (state_q == StRun);
  assign busy         = (state_q == StSeed) || (state_q == StRun) || (state_q == StDrain);
  assign done         = (state_q == StDone);
  assign pass         = pass_q;
  assign signature    = misr_q;
  assign abort_hit    = abort && busy;

  always_comb begin
    resp_ext              = '0;
    resp_ext[OUT_W-1:0]   = dut_out;
    misr_next             = {misr_q[MISR_W-2:0], 1'b0} ^
                            (misr_q[MISR_W-1] ? MISR_POLY : '0) ^ resp_ext;
  end

  // Capture strobe follows the applied-pattern strobe by the DUT's pipeline depth.
  if (DUT_LAT == 0) begin : g_comb_capture
    assign capture = dut_in_valid;
  end else begin : g_pipe_capture
    logic [DUT_LAT-1:0] pipe_q, pipe_d;

    always_comb begin
      pipe_d    = pipe_q << 1;
      pipe_d[0] = dut_in_valid;
    end

    always_ff @(posedge clk) begin
      if (rst || abort_hit) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign capture = pipe_q[DUT_LAT-1];
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;

    if (capture) begin
      misr_d = misr_next;
    end

    case (state_q)
      StIdle: begin
        if (start) state_d = StSeed;
      end
      StSeed: begin
        lfsr_d  = LFSR_SEED;
        misr_d  = '0;
        cnt_d   = '0;
        pass_d  = 1'b0;
        state_d = StRun;
      end
      StRun: begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == LastPat) begin
          if (DUT_LAT == 0) begin
            state_d = StDone;
          end else begin
            // Counter is reused to time the drain window.
            cnt_d   = '0;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == LastDrain) state_d = StDone;
      end
      StDone: begin
        if (start && !abort) begin
          pass_d  = 1'b0;
          state_d = StSeed;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort freezes the partial signature and pattern state.
    if (abort_hit) begin
      state_d = StIdle;
      lfsr_d  = lfsr_q;
      misr_d  = misr_q;
      cnt_d   = cnt_q;
    end

    if ((state_q != StDone) && (state_d == StDone)) begin
      pass_d = (misr_d == GOLDEN_SIG);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= '0;
      misr_q  <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: four parameterisations driven from one directed sequence, checked
// against an arithmetic model of the pattern generator and signature compactor.
module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   nchecks = 0;
  int   nerrs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Default parameters, random combinational DUT.
  logic        start_def, abort_def, vld_def, busy_def, done_def, pass_def;
  logic [20:0] din_def;
  logic [9:0]  dout_def;
  logic [15:0] sig_def;
  logic [9:0]  key_a, key_b;

  // NUM_PAT=1, response tied low.
  logic        start_p1, abort_p1, vld_p1, busy_p1, done_p1, pass_p1;
  logic [20:0] din_p1;
  logic [15:0] sig_p1;

  // NUM_PAT=2, response tied to 1.
  logic        start_p2, abort_p2, vld_p2, busy_p2, done_p2, pass_p2;
  logic [20:0] din_p2;
  logic [15:0] sig_p2;

  // DUT_LAT=3 with a three-stage registered identity DUT.
  logic        start_l3, abort_l3, vld_l3, busy_l3, done_l3, pass_l3;
  logic [20:0] din_l3;
  logic [9:0]  r1 = '0, r2 = '0, r3 = '0;
  logic [15:0] sig_l3;

  function automatic logic [9:0] comb_model(logic [20:0] x, logic [9:0] ka, logic [9:0] kb);
    return x[9:0] ^ x[19:10] ^ (x[20] ? ka : kb);
  endfunction

  assign dout_def = comb_model(din_def, key_a, key_b);

  always @(posedge clk) begin
    r1 <= din_l3[9:0];
    r2 <= r1;
    r3 <= r2;
  end

  gate_bist_ctrl u_def (
    .clk(clk), .rst(rst), .start(start_def), .abort(abort_def), .dut_in(din_def),
    .dut_in_valid(vld_def), .dut_out(dout_def), .busy(busy_def), .done(done_def),
    .pass(pass_def), .signature(sig_def)
  );

  gate_bist_ctrl #(.NUM_PAT(1), .DUT_LAT(0)) u_p1 (
    .clk(clk), .rst(rst), .start(start_p1), .abort(abort_p1), .dut_in(din_p1),
    .dut_in_valid(vld_p1), .dut_out(10'h000), .busy(busy_p1), .done(done_p1),
    .pass(pass_p1), .signature(sig_p1)
  );

  gate_bist_ctrl #(.NUM_PAT(2), .DUT_LAT(0)) u_p2 (
    .clk(clk), .rst(rst), .start(start_p2), .abort(abort_p2), .dut_in(din_p2),
    .dut_in_valid(vld_p2), .dut_out(10'h001), .busy(busy_p2), .done(done_p2),
    .pass(pass_p2), .signature(sig_p2)
  );

  gate_bist_ctrl #(.NUM_PAT(4), .DUT_LAT(3)) u_l3 (
    .clk(clk), .rst(rst), .start(start_l3), .abort(abort_l3), .dut_in(din_l3),
    .dut_in_valid(vld_l3), .dut_out(r3), .busy(busy_l3), .done(done_l3),
    .pass(pass_l3), .signature(sig_l3)
  );

  // Reference model: integer arithmetic on the shift/feedback rules.
  function automatic int lfsr_next(int s);
    int fb;
    fb = $countones(s & 32'h00E10000) % 2;
    return ((s * 2) % (1 << 24)) + fb;
  endfunction

  function automatic int misr_fold(int m, int d);
    int r;
    r = (m * 2) % 65536;
    if (m >= 32768) r = r ^ 32'h0000B400;
    return r ^ d;
  endfunction

  function automatic int ref_sig(int n, logic [9:0] ka, logic [9:0] kb);
    int s, m;
    s = 1;
    m = 0;
    for (int i = 0; i < n; i++) begin
      m = misr_fold(m, int'({22'd0, comb_model(21'(s), ka, kb)}));
      s = lfsr_next(s);
    end
    return m;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done_def(input int ts, output int lat);
    lat = -1;
    for (int i = 0; i < 400 && lat < 0; i++) begin
      if (done_def) lat = cyc - ts;
      else tick(1);
    end
  endtask

  task automatic chk_def_zero(input string tag);
    chk({tag, "_din"},  32'(din_def), 32'd0);
    chk({tag, "_vld"},  32'(vld_def), 32'd0);
    chk({tag, "_busy"}, 32'(busy_def), 32'd0);
    chk({tag, "_done"}, 32'(done_def), 32'd0);
    chk({tag, "_pass"}, 32'(pass_def), 32'd0);
    chk({tag, "_sig"},  32'(sig_def), 32'd0);
  endtask

  initial begin
    int ts, lat, s, exp_sig, exp_l3;

    rst = 1'b1;
    {start_def, abort_def, start_p1, abort_p1} = '0;
    {start_p2, abort_p2, start_l3, abort_l3} = '0;
    key_a = 10'($urandom);
    key_b = 10'($urandom);
    tick(3);
    chk_def_zero("reset");
    chk("reset_p1_done", 32'(done_p1), 32'd0);
    chk("reset_l3_sig", 32'(sig_l3), 32'd0);
    rst = 1'b0;
    tick(2);

    // Single pattern, zero response.
    start_p1 = 1'b1; ts = cyc; tick(1); start_p1 = 1'b0;
    chk("p1_seed_busy", 32'(busy_p1), 32'd1);
    chk("p1_seed_vld", 32'(vld_p1), 32'd0);
    tick(1);
    chk("p1_din", 32'(din_p1), 32'h1);
    chk("p1_vld", 32'(vld_p1), 32'd1);
    chk("p1_early_done", 32'(done_p1), 32'd0);
    tick(1);
    chk("p1_done_cycle", 32'(cyc - ts), 32'd3);
    chk("p1_done", 32'(done_p1), 32'd1);
    chk("p1_sig", 32'(sig_p1), 32'h0);
    chk("p1_pass", 32'(pass_p1), 32'd1);
    chk("p1_busy", 32'(busy_p1), 32'd0);

    // Two patterns, constant response 1.
    start_p2 = 1'b1; ts = cyc; tick(1); start_p2 = 1'b0;
    tick(1);
    chk("p2_din0", 32'(din_p2), 32'h1);
    tick(1);
    chk("p2_din1", 32'(din_p2), 32'h2);
    chk("p2_vld1", 32'(vld_p2), 32'd1);
    tick(1);
    chk("p2_done", 32'(done_p2), 32'd1);
    chk("p2_sig", 32'(sig_p2), 32'(misr_fold(misr_fold(0, 1), 1)));
    chk("p2_pass", 32'(pass_p2), 32'd0);

    // Pipelined DUT, latency 3.
    s = 1; exp_l3 = 0;
    for (int i = 0; i < 4; i++) begin
      exp_l3 = misr_fold(exp_l3, s % 1024);
      s = lfsr_next(s);
    end
    start_l3 = 1'b1; ts = cyc; tick(1); start_l3 = 1'b0;
    tick(7);
    chk("l3_not_done_c8", 32'(done_l3), 32'd0);
    chk("l3_busy_c8", 32'(busy_l3), 32'd1);
    tick(1);
    chk("l3_done_c9", 32'(done_l3), 32'd1);
    chk("l3_sig", 32'(sig_l3), 32'(exp_l3));
    chk("l3_pass", 32'(pass_l3), 32'(exp_l3 == 0));

    // Default run; start pulses inside RUN must not restart it.
    exp_sig = ref_sig(256, key_a, key_b);
    start_def = 1'b1; ts = cyc; tick(1); start_def = 1'b0;
    tick(1);
    s = 1;
    for (int i = 0; i < 8; i++) begin
      chk("def_din_seq", 32'(din_def), 32'(s));
      if (i == 2 || i == 5) start_def = 1'b1;
      tick(1);
      start_def = 1'b0;
      s = lfsr_next(s);
    end
    wait_done_def(ts, lat);
    chk("def_done_cycle", 32'(lat), 32'd258);
    chk("def_sig", 32'(sig_def), 32'(exp_sig));
    chk("def_pass", 32'(pass_def), 32'(exp_sig == 0));

    // Restart from DONE reproduces the signature.
    start_def = 1'b1; ts = cyc; tick(1); start_def = 1'b0;
    chk("restart_done_clr", 32'(done_def), 32'd0);
    chk("restart_busy", 32'(busy_def), 32'd1);
    chk("restart_pass_clr", 32'(pass_def), 32'd0);
    wait_done_def(ts, lat);
    chk("restart_done_cycle", 32'(lat), 32'd258);
    chk("restart_sig", 32'(sig_def), 32'(exp_sig));

    // start together with abort in DONE: no restart.
    start_def = 1'b1; abort_def = 1'b1; tick(1);
    start_def = 1'b0; abort_def = 1'b0;
    chk("done_abort_done", 32'(done_def), 32'd1);
    chk("done_abort_busy", 32'(busy_def), 32'd0);
    chk("done_abort_sig", 32'(sig_def), 32'(exp_sig));
    tick(1);
    chk("done_abort_busy2", 32'(busy_def), 32'd0);

    // Abort in the second RUN cycle.
    start_def = 1'b1; ts = cyc; tick(1); start_def = 1'b0;
    tick(2);
    chk("abort_run_vld", 32'(vld_def), 32'd1);
    abort_def = 1'b1; tick(1); abort_def = 1'b0;
    chk("abort_busy", 32'(busy_def), 32'd0);
    chk("abort_done", 32'(done_def), 32'd0);
    chk("abort_vld", 32'(vld_def), 32'd0);
    tick(2);
    chk("abort_stays_idle", 32'(busy_def), 32'd0);

    // Reset mid-RUN, then a fresh run with new response keys.
    start_def = 1'b1; ts = cyc; tick(1); start_def = 1'b0;
    tick(50);
    chk("midrun_busy", 32'(busy_def), 32'd1);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk_def_zero("midrun_reset");
    key_a = 10'($urandom);
    key_b = 10'($urandom);
    exp_sig = ref_sig(256, key_a, key_b);
    start_def = 1'b1; ts = cyc; tick(1); start_def = 1'b0;
    wait_done_def(ts, lat);
    chk("post_reset_done_cycle", 32'(lat), 32'd258);
    chk("post_reset_sig", 32'(sig_def), 32'(exp_sig));
    chk("post_reset_pass", 32'(pass_def), 32'(exp_sig == 0));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
